// File: rtl/udp_tx_arb.sv
// Round-robin arbiter over NUM_CH payload channels. Prepends an 8-byte UDP header
// to the granted channel's payload and streams the frame out with valid/ready.
module udp_tx_arb #(
   parameter int NUM_CH  = 4,
   parameter int MAX_LEN = 1472
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [15:0]           local_port,
   input  logic [15:0]           destination_port,
   input  logic [NUM_CH-1:0]     ch_req,
   input  logic [16*NUM_CH-1:0]  ch_len,
   input  logic [8*NUM_CH-1:0]   ch_port_id,
   input  logic [8*NUM_CH-1:0]   ch_data,
   output logic [NUM_CH-1:0]     ch_grant,
   output logic [NUM_CH-1:0]     ch_rd,
   output logic                  len_err,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [15:0]           length_out,
   output logic                  active
);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [16:0] MAX_LEN_L = 17'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   logic [15:0] len_arr  [NUM_CH];
   logic [7:0]  pid_arr  [NUM_CH];
   logic [7:0]  data_arr [NUM_CH];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign len_arr[gi]  = ch_len[16*gi +: 16];
         assign pid_arr[gi]  = ch_port_id[8*gi +: 8];
         assign data_arr[gi] = ch_data[8*gi +: 8];
      end
   endgenerate

   state_t             state_reg;
   logic [PTR_W-1:0]   rr_ptr_reg;
   logic [PTR_W-1:0]   sel_reg;
   logic [15:0]        src_reg;
   logic [15:0]        dst_reg;
   logic [15:0]        len_reg;
   logic [15:0]        count_reg;
   logic [15:0]        length_reg;
   logic [2:0]         hdr_idx_reg;
   logic [7:0]         hdr_byte_reg;
   logic [NUM_CH-1:0]  ch_grant_reg;
   logic               len_err_reg;
   logic               out_valid_reg;
   logic               out_sop_reg;
   logic               out_eop_reg;
   logic               active_reg;

   // Arbitration: lowest requester at or above the pointer wins, else lowest overall.
   logic [PTR_W-1:0]   pick_hi;
   logic [PTR_W-1:0]   pick_any;
   logic [PTR_W-1:0]   pick;
   logic [PTR_W-1:0]   next_ptr;
   logic               hit_hi;
   logic               req_hit;
   logic [NUM_CH-1:0]  grant_onehot;
   logic [15:0]        pick_len;
   logic [15:0]        pick_src;

   always_comb begin
      pick_hi  = '0;
      pick_any = '0;
      hit_hi   = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_req[i]) begin
            pick_any = PTR_W'(i);
            if (i >= int'(rr_ptr_reg)) begin
               pick_hi = PTR_W'(i);
               hit_hi  = 1'b1;
            end
         end
      end
   end

   assign req_hit  = |ch_req;
   assign pick     = hit_hi ? pick_hi : pick_any;
   assign next_ptr = (int'(pick) == NUM_CH - 1) ? '0 : pick + 1'b1;
   assign pick_len = len_arr[pick];
   assign pick_src = local_port + {8'h00, pid_arr[pick]};

   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
         assign grant_onehot[gi] = (pick == PTR_W'(gi));
         assign ch_rd[gi]        = (state_reg == PAY) && out_ready && (sel_reg == PTR_W'(gi));
      end
   endgenerate

   function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                           input logic [15:0] src,
                                           input logic [15:0] dst,
                                           input logic [15:0] ulen);
      case (idx)
         3'd0:    hdr_byte = src[15:8];
         3'd1:    hdr_byte = src[7:0];
         3'd2:    hdr_byte = dst[15:8];
         3'd3:    hdr_byte = dst[7:0];
         3'd4:    hdr_byte = ulen[15:8];
         3'd5:    hdr_byte = ulen[7:0];
         default: hdr_byte = 8'h00;
      endcase
   endfunction

   logic xfer;
   assign xfer = out_valid_reg & out_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         sel_reg       <= '0;
         src_reg       <= '0;
         dst_reg       <= '0;
         len_reg       <= '0;
         count_reg     <= '0;
         length_reg    <= '0;
         hdr_idx_reg   <= '0;
         hdr_byte_reg  <= '0;
         ch_grant_reg  <= '0;
         len_err_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_sop_reg   <= 1'b0;
         out_eop_reg   <= 1'b0;
         active_reg    <= 1'b0;
      end else begin
         ch_grant_reg <= '0;
         len_err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_hit) begin
                  ch_grant_reg <= grant_onehot;
                  rr_ptr_reg   <= next_ptr;
                  sel_reg      <= pick;
                  if ({1'b0, pick_len} > MAX_LEN_L) begin
                     len_err_reg <= 1'b1;
                  end else begin
                     state_reg     <= HDR;
                     src_reg       <= pick_src;
                     dst_reg       <= destination_port;
                     len_reg       <= pick_len;
                     length_reg    <= pick_len + 16'd8;
                     hdr_idx_reg   <= 3'd0;
                     hdr_byte_reg  <= pick_src[15:8];
                     out_valid_reg <= 1'b1;
                     out_sop_reg   <= 1'b1;
                     out_eop_reg   <= 1'b0;
                     active_reg    <= 1'b1;
                  end
               end
            end
            HDR: begin
               if (xfer) begin
                  out_sop_reg <= 1'b0;
                  hdr_idx_reg <= hdr_idx_reg + 3'd1;
                  if (hdr_idx_reg == 3'd7) begin
                     hdr_byte_reg <= 8'h00;
                     if (len_reg == 16'd0) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        out_eop_reg   <= 1'b0;
                        active_reg    <= 1'b0;
                     end else begin
                        state_reg   <= PAY;
                        count_reg   <= len_reg;
                        out_eop_reg <= (len_reg == 16'd1);
                     end
                  end else begin
                     hdr_byte_reg <= hdr_byte(hdr_idx_reg + 3'd1, src_reg, dst_reg, length_reg);
                     // Zero-length frames end on the last header byte.
                     out_eop_reg  <= (hdr_idx_reg == 3'd6) && (len_reg == 16'd0);
                  end
               end
            end
            PAY: begin
               if (xfer) begin
                  count_reg <= count_reg - 16'd1;
                  if (count_reg == 16'd1) begin
                     state_reg     <= IDLE;
                     out_valid_reg <= 1'b0;
                     out_eop_reg   <= 1'b0;
                     active_reg    <= 1'b0;
                  end else begin
                     out_eop_reg <= (count_reg == 16'd2);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_data   = (state_reg == PAY) ? data_arr[sel_reg] : hdr_byte_reg;
   assign out_valid  = out_valid_reg;
   assign out_sop    = out_sop_reg;
   assign out_eop    = out_eop_reg;
   assign active     = active_reg;
   assign ch_grant   = ch_grant_reg;
   assign len_err    = len_err_reg;
   assign length_out = length_reg;

endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
- Multi-channel successor to the single-stream UDP header prepender.
- Arbitrates round-robin among NUM_CH payload sources and prepends an 8-byte UDP header to the granted channel's payload. Source port is local_port + channel port ID.
- Emits the frame as a byte stream with valid/ready backpressure and SOP/EOP markers.
- Sits between the per-channel payload FIFOs (show-ahead) and the IP/MAC transmit layer.

Parameters:
- NUM_CH, 4, number of payload channels (1..16).
- MAX_LEN, 1472, largest payload length in bytes accepted per frame (≤ 65527).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- local_port  in  16  base UDP source port.
- destination_port  in  16  UDP destination port, common to all channels.
- ch_req  in  NUM_CH  per-channel frame request; held until granted.
- ch_len  in  16*NUM_CH  per-channel payload length; channel i at [16i+15:16i].
- ch_port_id  in  8*NUM_CH  per-channel offset added to local_port.
- ch_data  in  8*NUM_CH  per-channel show-ahead FIFO head byte.
- ch_grant  out  NUM_CH  one-hot, 1-cycle pulse when a request is accepted.
- ch_rd  out  NUM_CH  one-hot payload pop strobe.
- len_err  out  1  1-cycle pulse: granted request had ch_len > MAX_LEN and was dropped.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte this cycle.
- out_sop  out  1  first header byte (qualified by out_valid).
- out_eop  out  1  last frame byte (qualified by out_valid).
- length_out  out  16  UDP length (8 + payload) of the current frame; held until the next grant.
- active  out  1  high in HDR and PAY states.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE.
  - Outputs ch_grant, ch_rd, len_err, out_valid, out_sop, out_eop, active all 0.
  - out_data=0, length_out=0.
  - RR pointer=0, so channel 0 has highest priority.
  - Reset mid-frame aborts at once: no EOP, and no further ch_rd.
- States: IDLE, HDR, PAY. A byte transfers when out_valid & out_ready.
- IDLE:
  - If any ch_req is high, grant the first requester searching upward from the RR pointer, with wrap.
  - Registered: ch_grant[i] pulses on the cycle after the request is sampled.
  - ch_len[i] and ch_port_id[i] are latched in the same cycle; values later are ignored.
  - The RR pointer is set to i+1 mod NUM_CH.
  - If the latched len > MAX_LEN: pulse len_err with the grant, stay in IDLE, emit no bytes, pop nothing. The source must flush itself.
  - Otherwise go to HDR. length_out = 8 + len.
- HDR:
  - out_valid=1. Bytes, MSB first:
    - src = local_port + {8'h0, port_id}, 16-bit wrap.
    - dst = destination_port.
    - length_out.
    - checksum 16'h0000.
  - local_port and destination_port are sampled at grant.
  - out_sop=1 on byte 0.
  - Each byte advances only on transfer; out_ready low holds out_data and out_valid stable.
  - After byte 7 transfers: go to PAY if len>0, else go to IDLE. For len=0, out_eop is asserted on byte 7.
- PAY:
  - out_data = ch_data[sel] (combinational mux), out_valid=1.
  - ch_rd[sel] = out_ready (one pop per transferred byte).
  - The down-counter is loaded with len at entry and decrements per transfer.
  - out_eop=1 when count==1. After that transfer, go to IDLE.
- Frame spacing: IDLE lasts at least one cycle between frames. Next-frame arbitration occurs in that IDLE cycle.
  - Minimum frame period = 1 + 8 + len cycles with out_ready tied high.
- ch_req deasserted before grant: no grant. A requester that is never granted is harmless.
- Simultaneous requests: strictly round-robin. No channel is granted twice while another channel is continuously requesting.
- Payload underrun (FIFO empty) is the source's responsibility: a request must not be raised until len bytes are present.
- NUM_CH=1: the arbiter degenerates to a single channel. The pointer stays 0.

Test Plan:
1. Channel 2 alone: local_port=1024, port_id=3, destination_port=50000, len=4 with out_ready=1.
   - Expect ch_grant=4'b0100 pulse, then bytes 04 03 C3 50 00 0C 00 00 p0 p1 p2 p3.
   - SOP on byte 0, EOP on p3, length_out=12, exactly 4 ch_rd[2] pulses.
2. All four channels request continuously, len=2 each.
   - Expect grant order 0,1,2,3,0 and a 1-cycle IDLE gap between frames.
3. Backpressure: out_ready toggles 1,0,0,1,… through header and payload.
   - Expect no byte dropped or duplicated, out_data stable while stalled, ch_rd only on transfer cycles, 12 bytes total.
4. len=0 on channel 1.
   - Expect 8 header bytes with length field 00 08, EOP on byte 7, no ch_rd.
   - len=1473 on channel 1: expect len_err pulse with grant, no out_valid, and the next request is serviced normally.
5. Wraparound: local_port=16'hFFFE, port_id=5.
   - Expect source port bytes 00 03.
6. Reset low at payload byte 2 of a len=10 frame.
   - Expect next cycle out_valid=0, active=0, no EOP, ch_rd=0.
   - After release, channel 0 wins against simultaneous channels 0 and 3.
